// File: rtl/cache_mem_arbiter.sv
// Two-requester round-robin arbiter sharing one block-wide data memory
// between the instruction cache (rq0) and the data cache (rq1).
//
// Handshake: a requester holds read_en/wr_en with its address and data
// until it sees the matching done pulse. busywait_o stays high while it
// waits. On the memory side an enable is held, with a stable address and
// data, until the memory drops busywait and raises the done that matches
// the enable. The enable falls combinationally in that done cycle.
module cache_mem_arbiter #(
  parameter int BLOCK_W = 128,
  parameter int ADDR_W  = 28
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               rq0_read_en_i,
  input  logic               rq0_wr_en_i,
  input  logic [ADDR_W-1:0]  rq0_address_i,
  input  logic [BLOCK_W-1:0] rq0_write_data_i,
  output logic               rq0_busywait_o,
  output logic               rq0_read_done_o,
  output logic               rq0_write_done_o,
  output logic [BLOCK_W-1:0] rq0_read_data_o,
  input  logic               rq1_read_en_i,
  input  logic               rq1_wr_en_i,
  input  logic [ADDR_W-1:0]  rq1_address_i,
  input  logic [BLOCK_W-1:0] rq1_write_data_i,
  output logic               rq1_busywait_o,
  output logic               rq1_read_done_o,
  output logic               rq1_write_done_o,
  output logic [BLOCK_W-1:0] rq1_read_data_o,
  output logic               m_read_en_o,
  output logic               m_wr_en_o,
  output logic [ADDR_W-1:0]  m_address_o,
  output logic [BLOCK_W-1:0] m_write_data_o,
  input  logic               m_busywait_i,
  input  logic               m_read_done_i,
  input  logic               m_write_done_i,
  input  logic [BLOCK_W-1:0] m_read_data_i,
  output logic [1:0]         dbg_state_o,
  output logic               dbg_prio_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 op_wr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BLOCK_W-1:0]   data_q;

  logic                 latch_en;
  logic                 latch_sel;
  logic                 act0, act1;
  logic                 granted;
  logic                 done_match;

  assign act0 = rq0_read_en_i | rq0_wr_en_i;
  assign act1 = rq1_read_en_i | rq1_wr_en_i;
  assign granted = (state_q == GRANT0) || (state_q == GRANT1);

  // Only the done that matches the latched operation ends a grant.
  assign done_match = !m_busywait_i && (op_wr_q ? m_write_done_i : m_read_done_i);

  // State, round-robin pointer and the owner's latched request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (latch_en) begin
        op_wr_q <= latch_sel ? rq1_wr_en_i      : rq0_wr_en_i;
        addr_q  <= latch_sel ? rq1_address_i    : rq0_address_i;
        data_q  <= latch_sel ? rq1_write_data_i : rq0_write_data_i;
      end
    end
  end

  // Grant decision in IDLE, completion detection while granted.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    latch_en  = 1'b0;
    latch_sel = 1'b0;
    case (state_q)
      IDLE: begin
        if (act0 && act1) begin
          latch_en  = 1'b1;
          latch_sel = prio_q;
          state_d   = prio_q ? GRANT1 : GRANT0;
        end else if (act0) begin
          latch_en  = 1'b1;
          latch_sel = 1'b0;
          state_d   = GRANT0;
        end else if (act1) begin
          latch_en  = 1'b1;
          latch_sel = 1'b1;
          state_d   = GRANT1;
        end
      end
      GRANT0: begin
        if (done_match) begin
          state_d = RELEASE;
          prio_d  = 1'b1;
        end
      end
      GRANT1: begin
        if (done_match) begin
          state_d = RELEASE;
          prio_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory drive and per-requester status routing.
  always_comb begin
    m_read_en_o      = granted && !op_wr_q && !done_match;
    m_wr_en_o        = granted &&  op_wr_q && !done_match;
    m_address_o      = granted ? addr_q : '0;
    m_write_data_o   = (granted && op_wr_q) ? data_q : '0;

    rq0_busywait_o   = (state_q == GRANT0) | act0;
    rq0_read_done_o  = (state_q == GRANT0) && !op_wr_q && m_read_done_i;
    rq0_write_done_o = (state_q == GRANT0) &&  op_wr_q && m_write_done_i;
    rq0_read_data_o  = (state_q == GRANT0) ? m_read_data_i : '0;

    rq1_busywait_o   = (state_q == GRANT1) | act1;
    rq1_read_done_o  = (state_q == GRANT1) && !op_wr_q && m_read_done_i;
    rq1_write_done_o = (state_q == GRANT1) &&  op_wr_q && m_write_done_i;
    rq1_read_data_o  = (state_q == GRANT1) ? m_read_data_i : '0;

    dbg_state_o      = state_q;
    dbg_prio_o       = prio_q;
  end

endmodule
